// File: rtl/hdmi_fb_arbiter.sv
// hdmi_fb_arbiter: shares one SRAM port between display prefetch and two camera writers.
// Ports: clk_low/reset (sync, active-high); cam0/cam1 valid/ready/addr/data write streams
// with combinational ready; disp_frame_start/disp_pop/disp_rgb/disp_underflow display side;
// mem_addr/mem_wdata/mem_we/mem_re/mem_rdata registered SRAM port.
// Optional HDMI_FB_ARB_STATS_EN adds underflow_cnt[15:0], a saturating count of empty pops.
module hdmi_fb_arbiter #(
  parameter int FRAME_PIXELS = 307200,
  parameter int FIFO_DEPTH   = 16,
  parameter int LOW_WM       = 6,
  parameter int RD_LAT       = 2
) (
  input  logic        clk_low,
  input  logic        reset,
  input  logic        cam0_valid,
  output logic        cam0_ready,
  input  logic [20:0] cam0_addr,
  input  logic [23:0] cam0_data,
  input  logic        cam1_valid,
  output logic        cam1_ready,
  input  logic [20:0] cam1_addr,
  input  logic [23:0] cam1_data,
  input  logic        disp_frame_start,
  input  logic        disp_pop,
  output logic [23:0] disp_rgb,
  output logic        disp_underflow,
`ifdef HDMI_FB_ARB_STATS_EN
  output logic [15:0] underflow_cnt,
`endif
  output logic [20:0] mem_addr,
  output logic [23:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [23:0] mem_rdata
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + RD_LAT + 2);
  logic [23:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic [LW-1:0] count_q, count_d, level;
  logic [RD_LAT-1:0] pipe_q, pipe_d;
  logic [20:0] rd_ptr_q, rd_ptr_d, rd_cur;
  logic [20:0] mem_addr_q, mem_addr_d;
  logic [23:0] mem_wdata_q, mem_wdata_d, disp_rgb_q, disp_rgb_d;
  logic rr_last_q, rr_last_d, mem_we_q, mem_we_d, mem_re_q, mem_re_d, under_q, under_d;
  logic cam_any, pick1, urgent, cam_gnt, disp_gnt, push, pop_ok, pop_empty;
  always_comb begin
    // Level counts the read granted last cycle (now on mem_re) plus every read in the
    // return pipe, so a read is reserved a FIFO slot from the moment it is granted.
    level = LW'(mem_re_q);
    for (int i = 0; i < RD_LAT; i++) level = level + LW'(pipe_q[i]);
    level = disp_frame_start ? '0 : level + count_q;
    cam_any = cam0_valid | cam1_valid;
    pick1 = cam1_valid && (!cam0_valid || !rr_last_q);
    urgent = level < LW'(LOW_WM);
    cam_gnt = !reset && !urgent && cam_any;
    disp_gnt = !reset && (urgent || (!cam_any && level < LW'(FIFO_DEPTH)));
    cam0_ready = cam_gnt && !pick1;
    cam1_ready = cam_gnt && pick1;
    rr_last_d = cam_gnt ? pick1 : rr_last_q;
    rd_cur = disp_frame_start ? '0 : rd_ptr_q;
    rd_ptr_d = !disp_gnt ? rd_cur : rd_cur == 21'(FRAME_PIXELS - 1) ? '0 : rd_cur + 21'd1;
    mem_we_d = cam_gnt;
    mem_re_d = disp_gnt;
    mem_addr_d = disp_gnt ? rd_cur : cam_gnt ? (pick1 ? cam1_addr : cam0_addr) : mem_addr_q;
    mem_wdata_d = cam_gnt ? (pick1 ? cam1_data : cam0_data) : mem_wdata_q;
    // A frame start flushes the return pipe, so reads issued for the old frame never land.
    pipe_d = disp_frame_start ? '0 : (pipe_q << 1) | RD_LAT'(mem_re_q);
    push = pipe_q[RD_LAT-1] && !disp_frame_start;
    pop_ok = disp_pop && !disp_frame_start && count_q != '0;
    pop_empty = disp_pop && !disp_frame_start && count_q == '0;
    count_d = disp_frame_start ? '0 : count_q + LW'(push) - LW'(pop_ok);
    wr_idx_d = disp_frame_start ? '0 : wr_idx_q + AW'(push);
    rd_idx_d = disp_frame_start ? '0 : rd_idx_q + AW'(pop_ok);
    disp_rgb_d = (disp_frame_start || pop_empty) ? '0 : pop_ok ? fifo_mem[rd_idx_q] : disp_rgb_q;
    under_d = disp_frame_start ? 1'b0 : under_q | pop_empty;
  end
  always_ff @(posedge clk_low) if (push) fifo_mem[wr_idx_q] <= mem_rdata;
  always_ff @(posedge clk_low) begin
    if (reset) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      count_q <= '0;
      pipe_q <= '0;
      rd_ptr_q <= '0;
      rr_last_q <= 1'b1;
      mem_we_q <= 1'b0;
      mem_re_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      disp_rgb_q <= '0;
      under_q <= 1'b0;
    end else begin
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      count_q <= count_d;
      pipe_q <= pipe_d;
      rd_ptr_q <= rd_ptr_d;
      rr_last_q <= rr_last_d;
      mem_we_q <= mem_we_d;
      mem_re_q <= mem_re_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      disp_rgb_q <= disp_rgb_d;
      under_q <= under_d;
    end
  end
`ifdef HDMI_FB_ARB_STATS_EN
  logic [15:0] ucnt_q, ucnt_d;
  always_comb ucnt_d = ucnt_q + 16'(pop_empty && ucnt_q != 16'hFFFF);
  always_ff @(posedge clk_low) ucnt_q <= reset ? '0 : ucnt_d;
  assign underflow_cnt = ucnt_q;
`endif
  assign mem_we = mem_we_q;
  assign mem_re = mem_re_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign disp_rgb = disp_rgb_q;
  assign disp_underflow = under_q;
endmodule

// File: doc/hdmi_fb_arbiter.md
# hdmi_fb_arbiter

Arbiter and prefetch scheduler for the single-port stereo frame buffer that sits between the two camera writers and the HDMI transmitter pixel input. It shares one synchronous SRAM port between the display read stream and the two camera write streams, and keeps a small pixel FIFO topped up so that the transmitter's red/green/blue inputs never starve during the draw area. Display refill has priority when the FIFO runs low. Otherwise the cameras are served round-robin, and spare slots are used for display prefetch.

## Interface
- FRAME_PIXELS, 307200: pixels per displayed frame; the display read address wraps after FRAME_PIXELS-1.
- FIFO_DEPTH, 16: display pixel FIFO entries; must be a power of 2, ≥4.
- LOW_WM, 6: when fill level is below this value, display refill becomes urgent.
- RD_LAT, 2: SRAM read latency in cycles, from mem_re to mem_rdata valid; range 1..4.

Ports:
- clk_low  in  1  pixel clock, single clock domain.
- reset  in  1  synchronous, active-high.
- cam0_valid / cam1_valid  in  1  camera write request.
- cam0_ready / cam1_ready  out  1  write accepted this cycle; combinational grant.
- cam0_addr / cam1_addr  in  21  target pixel address.
- cam0_data / cam1_data  in  24  {r,g,b} pixel to write.
- disp_frame_start  in  1  one-cycle pulse before the first pixel of a frame.
- disp_pop  in  1  transmitter consumes one pixel (asserted on DrawArea cycles).
- disp_rgb  out  24  {red,green,blue} to the transmitter; registered.
- disp_underflow  out  1  sticky; set by a pop on an empty FIFO, cleared by reset or disp_frame_start.
- mem_addr  out  21  SRAM address.
- mem_wdata  out  24  SRAM write data.
- mem_we  out  1  SRAM write strobe.
- mem_re  out  1  SRAM read strobe.
- mem_rdata  in  24  SRAM read data, valid RD_LAT cycles after mem_re.

## Operation
- **Fill level.** level = fifo_count + inflight, where inflight is the number of reads issued but not yet returned. Display reads are issued only while level < FIFO_DEPTH, so the FIFO never overflows.
- **Per-cycle grant.** Exactly one of the following wins, in priority order:
  1. URGENT: level < LOW_WM → display read.
  2. CAM: one or both cam valid → round-robin. rr_last is the last camera served; when both are valid, the other camera wins. A single requester always wins. rr_last resets to cam1, so cam0 is served first.
  3. FILL: level < FIFO_DEPTH → display read.
  4. IDLE: nothing is issued.
- **Camera grant.** camN_ready is asserted in the grant cycle. The write fires when valid && ready, and mem_we/mem_addr/mem_wdata are registered on the next edge.
- **Display read.** mem_re pulses with mem_addr = rd_ptr. rd_ptr then increments, wrapping FRAME_PIXELS-1 → 0. Returned data is pushed into the FIFO RD_LAT cycles later.
- **disp_pop.** Registers the FIFO head into disp_rgb. A pop on an empty FIFO registers 24'h000000 and sets disp_underflow. Without a pop, disp_rgb holds its value.
- **disp_frame_start.**
  - Clears the FIFO and sets rd_ptr to 0.
  - Marks every read in flight as stale. Stale returns are discarded and do not push, tracked with a shift-register valid pipe of length RD_LAT.
  - A pop in the same cycle is ignored, and disp_rgb is set to 0.
  - Arbitration in that cycle uses level = 0, so the display wins (URGENT).
- **Push and pop in the same cycle** on a non-empty FIFO: the count is unchanged. A push onto an empty FIFO with a simultaneous pop yields an underflow; data is not bypassed.
- **Reset mid-operation.** In-flight reads are dropped, the FIFO is emptied, and there is no pending write. Any camera handshake that has not completed is not performed.

## Timing
- Reset values:
  - mem_we = 0, mem_re = 0, mem_addr = 0, mem_wdata = 0.
  - cam0_ready = cam1_ready = 0 in the reset cycle.
  - disp_rgb = 0, disp_underflow = 0, rd_ptr = 0, FIFO empty, rr_last = cam1.
- Camera write: handshake at edge N → mem_we = 1 during cycle N+1. Write throughput is 1 per cycle when the display is not urgent.
- Display: mem_re in cycle N → FIFO push at the edge ending cycle N+RD_LAT → poppable from cycle N+RD_LAT+1 → disp_rgb updated 1 cycle after the pop.
- Minimum display service: while urgent, the display gets every slot, so a 1-pixel-per-cycle draw area is sustained after the initial fill (FIFO_DEPTH+RD_LAT cycles of blanking).
- mem_we and mem_re are never both high in the same cycle.

## Configuration
- **HDMI_FB_ARB_STATS_EN**
  - Defined: adds output port underflow_cnt [15:0]. It counts pops on an empty FIFO, saturates at 16'hFFFF, is cleared only by reset (not by disp_frame_start), and resets to 0.
  - Undefined: the port and counter are absent; disp_underflow behaviour is unchanged.

## Test plan
- **Reset, then idle cams.** disp_frame_start at cycle 0 → mem_re on 16 consecutive cycles with addresses 0..15, then mem_re = 0 (level = FIFO_DEPTH); no mem_we.
- **Both cams valid continuously, no pops, FIFO full.** Grants alternate cam0, cam1, cam0…; mem_we on every cycle with the matching addr/data.
- **Pops every cycle plus both cams valid.** Level is held near LOW_WM; display reads take priority whenever level < 6; disp_underflow stays 0 and disp_rgb follows SRAM contents 0,1,2… in order.
- **disp_frame_start with 2 reads in flight (RD_LAT = 2).** The stale returns are not pushed; the next mem_re address is 0; the first popped pixel equals SRAM[0].
- **Pop 3 times on an empty FIFO after reset.** disp_rgb = 0 each time; disp_underflow = 1; with HDMI_FB_ARB_STATS_EN, underflow_cnt = 3.
- **rd_ptr wrap with FRAME_PIXELS = 8.** Read addresses run 6, 7, 0, 1 without a frame start.
